// File: rtl/ax_branch_decider.sv
// Approximate-branch decider: per-channel LFSR / periodic-counter decisions
// for the fetch slots, with decision and taken statistics.
module ax_branch_decider #(
  parameter int FETCH_WIDTH    = 2,
  parameter int NUM_CH         = 4,
  parameter int LFSR_WIDTH     = 16,
  parameter int AX_LEVEL_WIDTH = 4,
  parameter logic [LFSR_WIDTH-1:0] SEED = LFSR_WIDTH'(16'hACE1),
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic                      reseed,
  input  logic [1:0]                mode,
  input  logic                      lvlWe,
  input  logic [CH_W-1:0]           lvlWaddr,
  input  logic [AX_LEVEL_WIDTH-1:0] lvlWdata,
  input  logic [FETCH_WIDTH-1:0]    axbtbHit,
  input  logic [CH_W-1:0]           axChannel [FETCH_WIDTH],
  input  logic [FETCH_WIDTH-1:0]    btbHit,
  input  logic [FETCH_WIDTH-1:0]    brPredTaken,
  output logic [FETCH_WIDTH-1:0]    brDecidTaken,
  output logic [31:0]               decCount,
  output logic [31:0]               takenCount
);

  typedef enum logic [1:0] {
    MODE_OFF      = 2'd0,
    MODE_RANDOM   = 2'd1,
    MODE_PERIODIC = 2'd2,
    MODE_ALWAYS   = 2'd3
  } mode_e;

  localparam int PAD = LFSR_WIDTH - AX_LEVEL_WIDTH;

  // Fibonacci feedback masks (maximal-length); msb is always tapped so zero is unreachable
  function automatic logic [63:0] tap_mask(input int w);
    case (w)
      4:       tap_mask = 64'h0000_0000_0000_000C;
      8:       tap_mask = 64'h0000_0000_0000_00B8;
      12:      tap_mask = 64'h0000_0000_0000_0829;
      16:      tap_mask = 64'h0000_0000_0000_B400;
      24:      tap_mask = 64'h0000_0000_00E1_0000;
      32:      tap_mask = 64'h0000_0000_8020_0003;
      default: tap_mask = 64'h0000_0000_0000_0003 << (w - 2);
    endcase
  endfunction

  localparam logic [63:0]           TAPS64 = tap_mask(LFSR_WIDTH);
  localparam logic [LFSR_WIDTH-1:0] TAPS   = TAPS64[LFSR_WIDTH-1:0];

  function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] cur);
    lfsr_next = {cur[LFSR_WIDTH-2:0], ^(cur & TAPS)};
  endfunction

  function automatic logic [LFSR_WIDTH-1:0] seed_of(input int c);
    logic [LFSR_WIDTH-1:0] s;
    s = SEED + LFSR_WIDTH'(c);
    if (s == LFSR_WIDTH'(0)) s = LFSR_WIDTH'(1);
    return s;
  endfunction

  function automatic logic in_range(input logic [CH_W-1:0] ch);
    in_range = ({{(32-CH_W){1'b0}}, ch} < 32'(NUM_CH));
  endfunction

  logic [AX_LEVEL_WIDTH-1:0] level [NUM_CH];
  logic [LFSR_WIDTH-1:0]     lfsr  [NUM_CH];
  logic [AX_LEVEL_WIDTH-1:0] pcnt  [NUM_CH];
  logic [NUM_CH-1:0]         d;

  logic            act_valid;
  logic            act_ok;
  logic            blocked;
  logic [CH_W-1:0] act_ch;
  logic            act_d;
  logic            step_en;

  // Per-channel decision from current state and mode
  always_comb begin
    d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      case (mode)
        MODE_OFF:      d[c] = 1'b0;
        MODE_RANDOM:   d[c] = ((LFSR_WIDTH'(level[c]) << PAD) > lfsr[c]);
        MODE_PERIODIC: d[c] = (pcnt[c] < level[c]);
        MODE_ALWAYS:   d[c] = 1'b1;
        default:       d[c] = 1'b0;
      endcase
    end
  end

  // Slot outputs and selection of the single channel allowed to advance
  always_comb begin
    brDecidTaken = '0;
    act_valid    = 1'b0;
    act_ch       = '0;
    blocked      = 1'b0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (in_range(axChannel[i])) begin
        brDecidTaken[i] = axbtbHit[i] & d[axChannel[i]];
      end else begin
        brDecidTaken[i] = 1'b0;
      end
      // a predicted-taken branch in an earlier slot squashes later slots
      if (!act_valid && !blocked && axbtbHit[i]) begin
        act_valid = 1'b1;
        act_ch    = axChannel[i];
      end else begin
        act_ch    = act_ch;
      end
      blocked = blocked | (btbHit[i] & brPredTaken[i]);
    end
    act_ok  = act_valid & in_range(act_ch);
    if (act_ok) begin
      act_d = d[act_ch];
    end else begin
      act_d = 1'b0;
    end
    step_en = act_ok & ~stall & ~reseed & (mode != MODE_OFF);
  end

  // Level table, random sources, periodic counters and statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        level[c] <= '0;
        lfsr[c]  <= seed_of(c);
        pcnt[c]  <= '0;
      end
      decCount   <= 32'd0;
      takenCount <= 32'd0;
    end else begin
      if (lvlWe && in_range(lvlWaddr)) begin
        level[lvlWaddr] <= lvlWdata;
      end
      if (!stall) begin
        if (reseed) begin
          for (int c = 0; c < NUM_CH; c++) begin
            lfsr[c] <= seed_of(c);
            pcnt[c] <= '0;
          end
        end else if (step_en) begin
          case (mode)
            MODE_RANDOM:   lfsr[act_ch] <= lfsr_next(lfsr[act_ch]);
            MODE_PERIODIC: pcnt[act_ch] <= pcnt[act_ch] + AX_LEVEL_WIDTH'(1);
            default:       ;
          endcase
          decCount   <= decCount + 32'd1;
          takenCount <= takenCount + {31'd0, act_d};
        end
      end
    end
  end

endmodule

// File: tb/tb_ax_branch_decider.sv
// Self-checking bench for ax_branch_decider: directed scenarios plus a
// randomized run against a behavioural channel model.
module tb_ax_branch_decider;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        reseed;
  logic [1:0]  mode;
  logic        lvlWe;
  logic [1:0]  lvlWaddr;
  logic [3:0]  lvlWdata;
  logic [1:0]  axbtbHit;
  logic [1:0]  axChannel [2];
  logic [1:0]  btbHit;
  logic [1:0]  brPredTaken;
  logic [1:0]  brDecidTaken;
  logic [31:0] decCount;
  logic [31:0] takenCount;
  logic [1:0]  brDecidTaken3;
  logic [31:0] decCount3;
  logic [31:0] takenCount3;

  int total = 0;
  int bad   = 0;

  int          m_level [4];
  int          m_lfsr  [4];
  int          m_pcnt  [4];
  int unsigned m_dec;
  int unsigned m_taken;

  always #5 clk = ~clk;

  ax_branch_decider dut (
    .clk(clk), .rst(rst), .stall(stall), .reseed(reseed), .mode(mode),
    .lvlWe(lvlWe), .lvlWaddr(lvlWaddr), .lvlWdata(lvlWdata),
    .axbtbHit(axbtbHit), .axChannel(axChannel), .btbHit(btbHit),
    .brPredTaken(brPredTaken), .brDecidTaken(brDecidTaken),
    .decCount(decCount), .takenCount(takenCount)
  );

  ax_branch_decider #(.NUM_CH(3)) dut3 (
    .clk(clk), .rst(rst), .stall(stall), .reseed(reseed), .mode(mode),
    .lvlWe(lvlWe), .lvlWaddr(lvlWaddr), .lvlWdata(lvlWdata),
    .axbtbHit(axbtbHit), .axChannel(axChannel), .btbHit(btbHit),
    .brPredTaken(brPredTaken), .brDecidTaken(brDecidTaken3),
    .decCount(decCount3), .takenCount(takenCount3)
  );

  function automatic int seed(int c);
    int s;
    s = (32'hACE1 + c) & 32'hFFFF;
    if (s == 0) s = 1;
    return s;
  endfunction

  function automatic int lfsr_step(int v);
    int fb;
    fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
    return ((v << 1) & 32'hFFFF) | fb;
  endfunction

  function automatic bit model_d(int ch);
    if (ch >= 4) return 1'b0;
    case (mode)
      2'd1:    return (m_level[ch] * 4096) > m_lfsr[ch];
      2'd2:    return m_pcnt[ch] < m_level[ch];
      2'd3:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int model_active();
    for (int i = 0; i < 2; i++) begin
      if (axbtbHit[i]) return i;
      if (btbHit[i] && brPredTaken[i]) return -1;
    end
    return -1;
  endfunction

  function automatic logic [1:0] exp_out();
    logic [1:0] r;
    for (int i = 0; i < 2; i++) r[i] = axbtbHit[i] && model_d(int'(axChannel[i]));
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_level[c] = 0;
      m_lfsr[c]  = seed(c);
      m_pcnt[c]  = 0;
    end
    m_dec   = 0;
    m_taken = 0;
  endtask

  task automatic idle_inputs();
    stall = 1'b0; reseed = 1'b0; lvlWe = 1'b0; lvlWaddr = 2'd0; lvlWdata = 4'd0;
    axbtbHit = 2'b00; axChannel[0] = 2'd0; axChannel[1] = 2'd0;
    btbHit = 2'b00; brPredTaken = 2'b00;
  endtask

  // Advance one clock, updating the model from the pre-edge inputs
  task automatic tick();
    int a, ch, wa, wd, md;
    bit ad, we, st, rs;
    a  = model_active();
    ch = (a >= 0) ? int'(axChannel[a]) : 0;
    ad = (a >= 0) ? model_d(ch) : 1'b0;
    we = lvlWe; wa = int'(lvlWaddr); wd = int'(lvlWdata);
    st = stall; rs = reseed; md = int'(mode);
    @(posedge clk);
    if (we) m_level[wa] = wd;
    if (!st) begin
      if (rs) begin
        for (int c = 0; c < 4; c++) begin
          m_lfsr[c] = seed(c);
          m_pcnt[c] = 0;
        end
      end else if (a >= 0 && md != 0 && ch < 4) begin
        if (md == 1) m_lfsr[ch] = lfsr_step(m_lfsr[ch]);
        if (md == 2) m_pcnt[ch] = (m_pcnt[ch] + 1) % 16;
        m_dec++;
        if (ad) m_taken++;
      end
    end
    #1;
  endtask

  task automatic write_level(int ch, int v);
    lvlWe = 1'b1; lvlWaddr = 2'(ch); lvlWdata = 4'(v);
    tick();
    lvlWe = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    lvlWe = 1'b1; lvlWaddr = 2'd0; lvlWdata = 4'd5;
    mode = 2'd2; axbtbHit = 2'b01;
    rst = 1'b1;
    #1;
    total++; if (brDecidTaken !== 2'b00) begin bad++; $display("FAIL reset_out: got %b want 00", brDecidTaken); end
    total++; if (decCount !== 32'd0) begin bad++; $display("FAIL reset_dec: got %0d want 0", decCount); end
    total++; if (takenCount !== 32'd0) begin bad++; $display("FAIL reset_taken: got %0d want 0", takenCount); end
    mode = 2'd3;
    #1;
    total++; if (brDecidTaken !== 2'b01) begin bad++; $display("FAIL reset_always: got %b want 01", brDecidTaken); end
    @(posedge clk); #1;
    lvlWe = 1'b0; rst = 1'b0;
    model_reset();
    mode = 2'd2;
    #2;
    total++; if (brDecidTaken !== 2'b00) begin bad++; $display("FAIL reset_wr_discard: got %b want 00", brDecidTaken); end
    axbtbHit = 2'b00;
  endtask

  task automatic test_random_mode();
    mode = 2'd1;
    write_level(0, 8);
    axbtbHit = 2'b01; axChannel[0] = 2'd0;
    #2;
    total++; if (brDecidTaken !== 2'b00) begin bad++; $display("FAIL rnd_cyc1: got %b want 00", brDecidTaken); end
    tick(); #2;
    total++; if (brDecidTaken !== 2'b01) begin bad++; $display("FAIL rnd_cyc2: got %b want 01", brDecidTaken); end
    tick(); #2;
    total++; if (decCount !== 32'd2) begin bad++; $display("FAIL rnd_dec: got %0d want 2", decCount); end
    total++; if (takenCount !== 32'd1) begin bad++; $display("FAIL rnd_taken: got %0d want 1", takenCount); end
    axbtbHit = 2'b00;
  endtask

  task automatic test_periodic();
    bit pat [8];
    int unsigned t0;
    pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    reseed = 1'b1; tick(); reseed = 1'b0;
    mode = 2'd2;
    write_level(1, 3);
    t0 = m_taken;
    axbtbHit = 2'b01; axChannel[0] = 2'd1;
    for (int k = 0; k < 8; k++) begin
      #2;
      total++;
      if (brDecidTaken[0] !== pat[k]) begin
        bad++; $display("FAIL per_pattern[%0d]: got %b want %b", k, brDecidTaken[0], pat[k]);
      end
      tick();
    end
    total++; if (takenCount !== t0 + 3) begin bad++; $display("FAIL per_taken: got %0d want %0d", takenCount, t0 + 3); end
    axbtbHit = 2'b00;
  endtask

  task automatic test_blocked();
    int unsigned d0;
    mode = 2'd1;
    btbHit = 2'b01; brPredTaken = 2'b01;
    axbtbHit = 2'b10; axChannel[0] = 2'd2; axChannel[1] = 2'd0;
    d0 = m_dec;
    for (int k = 0; k < 3; k++) begin
      #2;
      total++;
      if (brDecidTaken !== {model_d(0), 1'b0}) begin
        bad++; $display("FAIL blk_out[%0d]: got %b want %b", k, brDecidTaken, {model_d(0), 1'b0});
      end
      tick();
    end
    total++; if (decCount !== d0) begin bad++; $display("FAIL blk_dec: got %0d want %0d", decCount, d0); end
    btbHit = 2'b00; brPredTaken = 2'b00; axbtbHit = 2'b00;
  endtask

  task automatic test_stall();
    int unsigned d0;
    mode = 2'd1; stall = 1'b1;
    axbtbHit = 2'b01; axChannel[0] = 2'd0;
    d0 = m_dec;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) begin lvlWe = 1'b1; lvlWaddr = 2'd0; lvlWdata = 4'd15; end
      #2;
      total++;
      if (brDecidTaken !== 2'b00) begin bad++; $display("FAIL stall_out[%0d]: got %b want 00", k, brDecidTaken); end
      tick();
    end
    lvlWe = 1'b0;
    #2;
    total++; if (decCount !== d0) begin bad++; $display("FAIL stall_dec: got %0d want %0d", decCount, d0); end
    total++; if (brDecidTaken !== 2'b01) begin bad++; $display("FAIL stall_wr: got %b want 01", brDecidTaken); end
    stall = 1'b0; axbtbHit = 2'b00;
  endtask

  task automatic test_two_slots();
    int unsigned d0;
    mode = 2'd1;
    write_level(2, 10);
    write_level(3, 10);
    axbtbHit = 2'b11; axChannel[0] = 2'd2; axChannel[1] = 2'd3;
    #2;
    total++; if (brDecidTaken !== 2'b00) begin bad++; $display("FAIL two_before: got %b want 00", brDecidTaken); end
    tick(); #2;
    total++; if (brDecidTaken !== 2'b01) begin bad++; $display("FAIL two_step: got %b want 01", brDecidTaken); end
    total++; if (m_lfsr[2] != 32'h59C7 || m_lfsr[3] != 32'hACE4) begin bad++; $display("FAIL two_model: got %h/%h want 59c7/ace4", m_lfsr[2], m_lfsr[3]); end
    d0 = m_dec;
    reseed = 1'b1;
    tick();
    reseed = 1'b0;
    #2;
    total++; if (brDecidTaken !== 2'b00) begin bad++; $display("FAIL two_reseed: got %b want 00", brDecidTaken); end
    total++; if (decCount !== d0) begin bad++; $display("FAIL two_dec: got %0d want %0d", decCount, d0); end
    axbtbHit = 2'b00;
  endtask

  task automatic test_randomized();
    int lv;
    for (int k = 0; k < 600; k++) begin
      if (k % 16 == 0) mode = 2'($urandom_range(0, 3));
      stall  = ($urandom_range(0, 7) == 0);
      reseed = ($urandom_range(0, 15) == 0);
      lvlWe  = ($urandom_range(0, 3) == 0);
      lvlWaddr = 2'($urandom_range(0, 3));
      lv = $urandom_range(0, 3);
      lvlWdata = (lv == 0) ? 4'd0 : (lv == 1) ? 4'd15 : 4'($urandom_range(0, 15));
      axbtbHit = 2'($urandom_range(0, 3));
      axChannel[0] = 2'($urandom_range(0, 3));
      axChannel[1] = 2'($urandom_range(0, 3));
      btbHit = 2'($urandom_range(0, 3));
      brPredTaken = 2'($urandom_range(0, 3));
      #2;
      total++; if (brDecidTaken !== exp_out()) begin bad++; $display("FAIL rand_out[%0d]: got %b want %b", k, brDecidTaken, exp_out()); end
      total++; if (decCount !== m_dec) begin bad++; $display("FAIL rand_dec[%0d]: got %0d want %0d", k, decCount, m_dec); end
      total++; if (takenCount !== m_taken) begin bad++; $display("FAIL rand_taken[%0d]: got %0d want %0d", k, takenCount, m_taken); end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_out_of_range();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    mode = 2'd3;
    axbtbHit = 2'b01; axChannel[0] = 2'd3;
    #2;
    total++; if (brDecidTaken3 !== 2'b00) begin bad++; $display("FAIL oor_out: got %b want 00", brDecidTaken3); end
    tick(); tick(); #2;
    total++; if (decCount3 !== 32'd0) begin bad++; $display("FAIL oor_dec: got %0d want 0", decCount3); end
    axChannel[0] = 2'd2;
    #2;
    total++; if (brDecidTaken3 !== 2'b01) begin bad++; $display("FAIL oor_inrange: got %b want 01", brDecidTaken3); end
    tick(); #2;
    total++; if (decCount3 !== 32'd1 || takenCount3 !== 32'd1) begin bad++; $display("FAIL oor_cnt: got %0d/%0d want 1/1", decCount3, takenCount3); end
    total++; if (decCount !== m_dec) begin bad++; $display("FAIL oor_main_dec: got %0d want %0d", decCount, m_dec); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_random_mode();
    test_periodic();
    test_blocked();
    test_stall();
    test_two_slots();
    test_randomized();
    test_out_of_range();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
